// File: rtl/maze_solver.sv
// Wall-follower maze explorer: walks a 1=wall/0=free RAM by the right- or left-hand rule.
// Optional step_count output port when MAZE_STEP_COUNT_EN is defined.
module maze_solver #(
    parameter int maze_width = 6,
    parameter int MAZE_ROWS  = 64,
    parameter int MAZE_COLS  = 64,
    parameter int HAND       = 0,
    parameter int MAX_STEPS  = 4095,
    parameter int STEP_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [maze_width-1:0] starting_row,
    input  logic [maze_width-1:0] starting_col,
    input  logic                  maze_in,
    output logic [maze_width-1:0] row,
    output logic [maze_width-1:0] col,
    output logic                  maze_oe,
    output logic                  maze_we,
    output logic                  busy,
    output logic                  done,
    output logic                  fail
`ifdef MAZE_STEP_COUNT_EN
    ,
    output logic [STEP_W-1:0]     step_count
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_MARK, S_PROBE, S_CHECK, S_MOVE, S_DONE, S_FAIL} state_t;
    typedef enum logic [1:0] {EAST, SOUTH, WEST, NORTH} dir_t;

    localparam logic [maze_width-1:0] LAST_ROW  = maze_width'(MAZE_ROWS - 1);
    localparam logic [maze_width-1:0] LAST_COL  = maze_width'(MAZE_COLS - 1);
    localparam logic [STEP_W-1:0]     STEP_LIM  = STEP_W'(MAX_STEPS);
    localparam logic signed [maze_width:0] ONE  = 1;

    state_t                state;
    dir_t                  heading;
    logic [1:0]            cand;
    logic [maze_width-1:0] cur_row;
    logic [maze_width-1:0] cur_col;
    logic [STEP_W-1:0]     steps;

    dir_t                  cand_dir;
    logic signed [maze_width:0] nb_row;
    logic signed [maze_width:0] nb_col;
    logic                  off_grid;
    logic                  at_edge;

    // Directions are numbered clockwise, so a right turn is +1 and a left turn is +3.
    always_comb begin
        logic [1:0] turn;
        turn = 2'd0;
        case (cand)
            2'd0:    turn = (HAND != 0) ? 2'd3 : 2'd1;
            2'd1:    turn = 2'd0;
            2'd2:    turn = (HAND != 0) ? 2'd1 : 2'd3;
            default: turn = 2'd2;
        endcase
        cand_dir = dir_t'(heading + turn);
    end

    // One extra signed bit lets both -1 and the wrap past the top index read as off-grid.
    always_comb begin
        nb_row = $signed({1'b0, cur_row});
        nb_col = $signed({1'b0, cur_col});
        case (cand_dir)
            EAST:    nb_col = nb_col + ONE;
            SOUTH:   nb_row = nb_row + ONE;
            WEST:    nb_col = nb_col - ONE;
            default: nb_row = nb_row - ONE;
        endcase
        off_grid = nb_row[maze_width] || nb_col[maze_width]
                || (int'(nb_row) >= MAZE_ROWS) || (int'(nb_col) >= MAZE_COLS);
        at_edge  = (cur_row == '0) || (cur_row == LAST_ROW)
                || (cur_col == '0) || (cur_col == LAST_COL);
    end

    // NOTE: every output is a register assigned with <= so the RAM sees glitch-free strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            heading <= EAST;
            cand    <= 2'd0;
            cur_row <= '0;
            cur_col <= '0;
            steps   <= '0;
            row     <= '0;
            col     <= '0;
            maze_oe <= 1'b0;
            maze_we <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            fail    <= 1'b0;
        end else begin
            maze_oe <= 1'b0;
            maze_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        cur_row <= starting_row;
                        cur_col <= starting_col;
                        row     <= starting_row;
                        col     <= starting_col;
                        heading <= EAST;
                        steps   <= '0;
                        done    <= 1'b0;
                        fail    <= 1'b0;
                        busy    <= 1'b1;
                        maze_we <= 1'b1;
                        state   <= S_MARK;
                    end
                end
                S_MARK: begin
                    cand  <= 2'd0;
                    state <= S_PROBE;
                end
                S_PROBE: begin
                    if (!off_grid) begin
                        row     <= nb_row[maze_width-1:0];
                        col     <= nb_col[maze_width-1:0];
                        maze_oe <= 1'b1;
                        state   <= S_CHECK;
                    end else if (cand == 2'd3) begin
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_FAIL;
                    end else begin
                        cand <= cand + 2'd1;
                    end
                end
                S_CHECK: begin
                    if (maze_in) begin
                        row <= cur_row;
                        col <= cur_col;
                        if (cand == 2'd3) begin
                            fail  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_FAIL;
                        end else begin
                            cand  <= cand + 2'd1;
                            state <= S_PROBE;
                        end
                    end else begin
                        // row/col already point at the free neighbour; it becomes the current cell.
                        cur_row <= row;
                        cur_col <= col;
                        heading <= cand_dir;
                        steps   <= steps + STEP_W'(1);
                        maze_we <= 1'b1;
                        state   <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    if (at_edge) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else if (steps == STEP_LIM) begin
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_FAIL;
                    end else begin
                        cand  <= 2'd0;
                        state <= S_PROBE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MAZE_STEP_COUNT_EN
    assign step_count = steps;
`endif

endmodule
